ecc_mem_ctrl: RTL and testbench
===============================

ECC_MEM_CTRL -- requirements
Module: ecc_mem_ctrl

Interface
REQ-001 SHALL have parameter WR_WAIT, default 2, meaning write-strobe width in cycles (legal 1..15).
REQ-002 SHALL have parameter RD_WAIT, default 3, meaning read access wait in cycles (legal 1..15).
REQ-003 SHALL have port clk  in  1  meaning single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port req  in  1  meaning MCU transaction request.
REQ-006 SHALL have port req_we  in  1  meaning 1 = write both memories, 0 = read both memories.
REQ-007 SHALL have port ecc_sel_in  in  3  meaning ECC mode requested for this transaction.
REQ-008 SHALL have port flag  in  3  meaning ECC decoder status (000 = clean, any nonzero = error).
REQ-009 SHALL have port err_clr  in  1  meaning clear error counter.
REQ-010 SHALL have port busy  out  1  meaning transaction in progress; req is ignored while high.
REQ-011 SHALL have port ack  out  1  meaning one-cycle completion pulse.
REQ-012 SHALL have port mem_ce_n, mem_we_n, mem_oe_n  out  1 each  meaning active-low strobes shared by the up and down memories.
REQ-013 SHALL have port bus_drive  out  1  meaning 1 = FPGA drives both memory buses (encoder output), 0 = buses tristated.
REQ-014 SHALL have port rd_latch  out  1  meaning one-cycle pulse to capture decoder output toward the MCU.
REQ-015 SHALL have port ecc_sel  out  3  meaning ECC mode held stable for the whole transaction.
REQ-016 SHALL have port flag_out  out  3  meaning latched ECC status of the last transaction.
REQ-017 SHALL have port err_cnt  out  8  meaning saturating count of reads with nonzero flag.
REQ-018 SHALL have port err_irq  out  1  meaning one-cycle pulse when a read completes with nonzero flag.

Function
REQ-019 SHALL use states IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT, RD_CAPTURE, DONE.
REQ-020 SHALL accept a request when state is IDLE and req=1: latch req_we and ecc_sel_in (ecc_sel updates the next cycle), go to WR_SETUP or RD_SETUP.
REQ-021 SHALL decode busy, mem_ce_n, mem_we_n, mem_oe_n, bus_drive, rd_latch and ack from the registered state only (no input-to-output combinational path).
REQ-022 SHALL drive busy=1 in every state except IDLE.
REQ-023 SHALL drive in WR_SETUP: ce_n=0, we_n=1, oe_n=1, bus_drive=1; 1 cycle.
REQ-024 SHALL drive in WR_PULSE: ce_n=0, we_n=0, bus_drive=1; exactly WR_WAIT cycles via a 4-bit down-counter.
REQ-025 SHALL drive in WR_HOLD: ce_n=0, we_n=1, bus_drive=1; 1 cycle; then DONE.
REQ-026 SHALL drive in RD_SETUP and RD_WAIT: ce_n=0, oe_n=0, we_n=1, bus_drive=0; RD_SETUP 1 cycle, RD_WAIT exactly RD_WAIT cycles.
REQ-027 SHALL in RD_CAPTURE keep ce_n=0 and oe_n=0, pulse rd_latch=1, and register flag into flag_out; 1 cycle; then DONE.
REQ-028 SHALL in DONE drive ack=1 with all strobes inactive and bus_drive=0; 1 cycle; then IDLE. A new request is accepted no earlier than the cycle after DONE.
REQ-029 SHALL never assert bus_drive=1 and mem_oe_n=0 in the same cycle.
REQ-030 SHALL set flag_out=000 on write acceptance; flag_out otherwise holds its value.
REQ-031 SHALL in DONE of a read with nonzero captured flag pulse err_irq and increment err_cnt, saturating at 255.
REQ-032 SHALL clear err_cnt to 0 on err_clr=1; err_clr wins over a simultaneous increment.
REQ-033 SHALL hold ecc_sel from acceptance until the next acceptance.

Reset
REQ-034 SHALL on rst=1 at any clock edge, including mid-transaction, enter IDLE next cycle with busy=0, ack=0, mem_ce_n=1, mem_we_n=1, mem_oe_n=1, bus_drive=0, rd_latch=0, err_irq=0, ecc_sel=000, flag_out=000, err_cnt=0, wait counter=0.
REQ-035 SHALL have rst take priority over req and err_clr.

Verification
REQ-036 Write, defaults, req=1/req_we=1 at cycle 0 -> WR_SETUP c1, we_n=0 c2-c3, HOLD c4, ack c5, bus_drive=1 c1-c4, flag_out=000.
REQ-037 Read, flag=3'b010 -> oe_n=0 c1-c5, rd_latch c5, ack c6, flag_out=010 from c6, err_irq c6, err_cnt=1.
REQ-038 req held high through a transaction -> second transaction accepted in the IDLE cycle after ack; ecc_sel changes only at acceptance.
REQ-039 rst asserted during WR_PULSE -> next cycle all strobes inactive, bus_drive=0, busy=0, no ack.
REQ-040 256 erroneous reads then err_clr coincident with a 257th error -> err_cnt saturates at 255 and then reads 0.
REQ-041 WR_WAIT=1, RD_WAIT=15 -> write ack at c4, read ack at c18; bus_drive and oe_n=0 never overlap.

Source files
------------

// File: rtl/ecc_mem_ctrl.sv
// Strobe sequencer for a pair of ECC-protected asynchronous memories (up/down) behind an MCU.
// Generates shared CE/WE/OE timing, bus direction, decoder capture and error accounting.
module ecc_mem_ctrl #(
    parameter int unsigned WR_WAIT = 2,
    parameter int unsigned RD_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_we,
    input  logic [2:0] ecc_sel_in,
    input  logic [2:0] flag,
    input  logic       err_clr,
    output logic       busy,
    output logic       ack,
    output logic       mem_ce_n,
    output logic       mem_we_n,
    output logic       mem_oe_n,
    output logic       bus_drive,
    output logic       rd_latch,
    output logic [2:0] ecc_sel,
    output logic [2:0] flag_out,
    output logic [7:0] err_cnt,
    output logic       err_irq
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 8;
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_SETUP,
        ST_RD_WAIT,
        ST_RD_CAPTURE,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             accept;
    logic             err_hit;

    logic             busy_nxt;
    logic             ack_nxt;
    logic             ce_n_nxt;
    logic             we_n_nxt;
    logic             oe_n_nxt;
    logic             drive_nxt;
    logic             latch_nxt;

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        err_hit      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = req_we ? ST_WR_SETUP : ST_RD_SETUP;
                end
            end
            ST_WR_SETUP: begin
                state_nxt    = ST_WR_PULSE;
                wait_cnt_nxt = WR_LOAD;
            end
            ST_WR_PULSE: begin
                if (wait_cnt == '0) state_nxt = ST_WR_HOLD;
                else                wait_cnt_nxt = wait_cnt - CNT_W'(1);
            end
            ST_WR_HOLD:  state_nxt = ST_DONE;
            ST_RD_SETUP: begin
                state_nxt    = ST_RD_WAIT;
                wait_cnt_nxt = RD_LOAD;
            end
            ST_RD_WAIT: begin
                if (wait_cnt == '0) state_nxt = ST_RD_CAPTURE;
                else                wait_cnt_nxt = wait_cnt - CNT_W'(1);
            end
            ST_RD_CAPTURE: begin
                state_nxt = ST_DONE;
                err_hit   = (flag != 3'b000);
            end
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Strobe decode of the upcoming state; registered so each output matches the state it belongs to
    always_comb begin
        busy_nxt  = 1'b1;
        ack_nxt   = 1'b0;
        ce_n_nxt  = 1'b0;
        we_n_nxt  = 1'b1;
        oe_n_nxt  = 1'b1;
        drive_nxt = 1'b0;
        latch_nxt = 1'b0;
        case (state_nxt)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                ce_n_nxt = 1'b1;
            end
            ST_WR_SETUP, ST_WR_HOLD: drive_nxt = 1'b1;
            ST_WR_PULSE: begin
                we_n_nxt  = 1'b0;
                drive_nxt = 1'b1;
            end
            ST_RD_SETUP, ST_RD_WAIT: oe_n_nxt = 1'b0;
            ST_RD_CAPTURE: begin
                oe_n_nxt  = 1'b0;
                latch_nxt = 1'b1;
            end
            ST_DONE: begin
                ack_nxt  = 1'b1;
                ce_n_nxt = 1'b1;
            end
            default: begin
                busy_nxt = 1'b0;
                ce_n_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            ack       <= 1'b0;
            mem_ce_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            bus_drive <= 1'b0;
            rd_latch  <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            busy      <= busy_nxt;
            ack       <= ack_nxt;
            mem_ce_n  <= ce_n_nxt;
            mem_we_n  <= we_n_nxt;
            mem_oe_n  <= oe_n_nxt;
            bus_drive <= drive_nxt;
            rd_latch  <= latch_nxt;
        end
    end

    // Transaction mode, decoder status and error accounting; the irq pulse lands on DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            ecc_sel  <= 3'b000;
            flag_out <= 3'b000;
            err_cnt  <= '0;
            err_irq  <= 1'b0;
        end else begin
            err_irq <= err_hit;
            if (accept) begin
                ecc_sel <= ecc_sel_in;
                if (req_we) flag_out <= 3'b000;
            end else if (state == ST_RD_CAPTURE) begin
                flag_out <= flag;
            end
            if (err_clr)                          err_cnt <= '0;
            else if (err_hit && err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Self-checking bench for ecc_mem_ctrl: randomized transactions against a phase-length model,
// plus back-to-back, mid-transaction reset, error saturation/clear and extreme wait settings.
module tb_ecc_mem_ctrl;

    localparam int WW  = 2;
    localparam int RW  = 3;
    localparam int WW2 = 1;
    localparam int RW2 = 15;
    localparam logic [6:0] IDLE_VEC = 7'b0011100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       req_we = 1'b0;
    logic [2:0] ecc_sel_in = 3'b000;
    logic [2:0] flag = 3'b000;
    logic       err_clr = 1'b0;

    logic       d1_busy, d1_ack, d1_ce_n, d1_we_n, d1_oe_n, d1_drive, d1_latch, d1_irq;
    logic [2:0] d1_sel, d1_flag;
    logic [7:0] d1_cnt;
    logic       d2_busy, d2_ack, d2_ce_n, d2_we_n, d2_oe_n, d2_drive, d2_latch, d2_irq;
    logic [2:0] d2_sel, d2_flag;
    logic [7:0] d2_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    ecc_mem_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .ecc_sel_in(ecc_sel_in),
        .flag(flag), .err_clr(err_clr), .busy(d1_busy), .ack(d1_ack),
        .mem_ce_n(d1_ce_n), .mem_we_n(d1_we_n), .mem_oe_n(d1_oe_n),
        .bus_drive(d1_drive), .rd_latch(d1_latch), .ecc_sel(d1_sel),
        .flag_out(d1_flag), .err_cnt(d1_cnt), .err_irq(d1_irq)
    );

    ecc_mem_ctrl #(.WR_WAIT(WW2), .RD_WAIT(RW2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .ecc_sel_in(ecc_sel_in),
        .flag(flag), .err_clr(err_clr), .busy(d2_busy), .ack(d2_ack),
        .mem_ce_n(d2_ce_n), .mem_we_n(d2_we_n), .mem_oe_n(d2_oe_n),
        .bus_drive(d2_drive), .rd_latch(d2_latch), .ecc_sel(d2_sel),
        .flag_out(d2_flag), .err_cnt(d2_cnt), .err_irq(d2_irq)
    );

    wire [6:0] v1 = {d1_busy, d1_ack, d1_ce_n, d1_we_n, d1_oe_n, d1_drive, d1_latch};
    wire [6:0] v2 = {d2_busy, d2_ack, d2_ce_n, d2_we_n, d2_oe_n, d2_drive, d2_latch};

    // Expected {busy,ack,ce_n,we_n,oe_n,bus_drive,rd_latch} in cycle k after acceptance (k=0 is the req cycle)
    function automatic logic [6:0] exp_vec(input logic we, input int k, input int ww, input int rw);
        int len;
        len = we ? ww + 3 : rw + 3;
        if (k < 1 || k > len) return IDLE_VEC;
        if (k == len) return 7'b1111100;
        if (we) begin
            if (k == 1 || k == len - 1) return 7'b1001110;
            return 7'b1000110;
        end
        if (k == len - 1) return 7'b1001001;
        return 7'b1001000;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b1; req_we = 1'b1; err_clr = 1'b1; ecc_sel_in = 3'b101;
        repeat (2) @(negedge clk);
        checks++;
        if (v1 !== IDLE_VEC || v2 !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_strobes got %b/%b want %b", v1, v2, IDLE_VEC);
        end
        checks++;
        if ({d1_sel, d1_flag, d1_cnt, d1_irq} !== 15'd0 || {d2_sel, d2_flag, d2_cnt, d2_irq} !== 15'd0) begin
            errors++;
            $display("FAIL reset_status got %h/%h want 0", {d1_sel, d1_flag, d1_cnt, d1_irq},
                     {d2_sel, d2_flag, d2_cnt, d2_irq});
        end
        rst = 1'b0; req = 1'b0; err_clr = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        checks++;
        if (v1 !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_release got %b want %b", v1, IDLE_VEC);
        end
    endtask

    task automatic test_random_txn();
        logic [2:0] exp_flag;
        exp_flag = d1_flag === 3'bxxx ? 3'b000 : 3'b000;
        for (int n = 0; n < 30; n++) begin
            logic       we;
            logic       exp_irq;
            logic [2:0] sel, flg;
            int         len;
            we  = 1'($urandom_range(0, 1));
            sel = 3'($urandom);
            flg = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            len = we ? WW + 3 : RW + 3;
            @(negedge clk);
            req = 1'b1; req_we = we; ecc_sel_in = sel; flag = flg;
            for (int k = 1; k <= len + 1; k++) begin
                @(negedge clk);
                req = 1'b0;
                if (k == 1 && we) exp_flag = 3'b000;
                if (k == len && !we) exp_flag = flg;
                exp_irq = (k == len) && !we && (flg != 3'b000);
                if (k == len + 1 && !we && flg != 3'b000 && exp_cnt != 255) exp_cnt++;
                checks++;
                if (v1 !== exp_vec(we, k, WW, RW)) begin
                    errors++;
                    $display("FAIL txn_strobes n=%0d we=%0b k=%0d got %b want %b", n, we, k, v1, exp_vec(we, k, WW, RW));
                end
                checks++;
                if ({d1_sel, d1_flag, d1_irq} !== {sel, exp_flag, exp_irq}) begin
                    errors++;
                    $display("FAIL txn_status n=%0d k=%0d sel/flag/irq got %0d/%0d/%0b want %0d/%0d/%0b",
                             n, k, d1_sel, d1_flag, d1_irq, sel, exp_flag, exp_irq);
                end
                checks++;
                if (d1_drive === 1'b1 && d1_oe_n === 1'b0) begin
                    errors++;
                    $display("FAIL bus_overlap n=%0d k=%0d got drive=1 oe_n=0 want exclusive", n, k);
                end
                if (k == len + 1) begin
                    checks++;
                    if (d1_cnt !== 8'(exp_cnt)) begin
                        errors++;
                        $display("FAIL txn_err_cnt n=%0d got %0d want %0d", n, d1_cnt, exp_cnt);
                    end
                end
                ecc_sel_in = 3'($urandom);
                if (k == len) flag = 3'($urandom);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] sel_a, sel_b, exp_sel;
        int len1, len2, k2;
        len1 = WW + 3;
        len2 = RW + 3;
        sel_a = 3'($urandom);
        sel_b = 3'b000;
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; ecc_sel_in = sel_a; flag = 3'b000;
        for (int k = 1; k <= len1 + len2 + 2; k++) begin
            @(negedge clk);
            exp_sel = (k <= len1 + 1) ? sel_a : sel_b;
            k2 = k - (len1 + 1);
            checks++;
            if (k <= len1 + 1 ? (v1 !== exp_vec(1'b1, k, WW, RW)) : (v1 !== exp_vec(1'b0, k2, WW, RW))) begin
                errors++;
                $display("FAIL b2b_strobes k=%0d got %b want %b", k, v1,
                         k <= len1 + 1 ? exp_vec(1'b1, k, WW, RW) : exp_vec(1'b0, k2, WW, RW));
            end
            checks++;
            if (d1_sel !== exp_sel) begin
                errors++;
                $display("FAIL b2b_ecc_sel k=%0d got %0d want %0d", k, d1_sel, exp_sel);
            end
            req_we = 1'b0;
            ecc_sel_in = 3'($urandom);
            if (k == len1 + 1) sel_b = ecc_sel_in;
            if (k == len1 + 2) req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; ecc_sel_in = 3'b110;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (k <= 2) begin
                checks++;
                if (v1 !== exp_vec(1'b1, k, WW, RW)) begin
                    errors++;
                    $display("FAIL midrst_pre k=%0d got %b want %b", k, v1, exp_vec(1'b1, k, WW, RW));
                end
            end else begin
                checks++;
                if (v1 !== IDLE_VEC) begin
                    errors++;
                    $display("FAIL midrst_idle k=%0d got %b want %b", k, v1, IDLE_VEC);
                end
            end
            if (k == 3) begin
                checks++;
                if ({d1_sel, d1_flag, d1_cnt, d1_irq} !== 15'd0) begin
                    errors++;
                    $display("FAIL midrst_status got %h want 0", {d1_sel, d1_flag, d1_cnt, d1_irq});
                end
            end
            rst = (k == 2);
        end
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_err_saturate();
        int len;
        logic clr_txn;
        len = RW + 3;
        pulse_reset();
        for (int n = 1; n <= 259; n++) begin
            clr_txn = (n == 257 || n == 258);
            @(negedge clk);
            req = 1'b1; req_we = 1'b0; flag = 3'($urandom_range(1, 7));
            for (int k = 1; k <= len + 1; k++) begin
                @(negedge clk);
                req = 1'b0;
                if (k == len) begin
                    checks++;
                    if (d1_irq !== 1'b1) begin
                        errors++;
                        $display("FAIL sat_irq n=%0d got %b want 1", n, d1_irq);
                    end
                end
                if (k == len + 1) begin
                    if (clr_txn) exp_cnt = 0;
                    else if (exp_cnt != 255) exp_cnt++;
                    checks++;
                    if (d1_cnt !== 8'(exp_cnt)) begin
                        errors++;
                        $display("FAIL sat_err_cnt n=%0d got %0d want %0d", n, d1_cnt, exp_cnt);
                    end
                    err_clr = 1'b0;
                end
                if (clr_txn && k == len - 1) err_clr = 1'b1;
            end
        end
    endtask

    task automatic test_params();
        pulse_reset();
        for (int t = 0; t < 2; t++) begin
            logic we;
            int   len;
            we  = (t == 0);
            len = we ? WW2 + 3 : RW2 + 3;
            @(negedge clk);
            req = 1'b1; req_we = we; ecc_sel_in = 3'($urandom); flag = 3'($urandom);
            for (int k = 1; k <= len + 1; k++) begin
                @(negedge clk);
                req = 1'b0;
                checks++;
                if (v2 !== exp_vec(we, k, WW2, RW2)) begin
                    errors++;
                    $display("FAIL param_strobes we=%0b k=%0d got %b want %b", we, k, v2, exp_vec(we, k, WW2, RW2));
                end
                checks++;
                if (d2_drive === 1'b1 && d2_oe_n === 1'b0) begin
                    errors++;
                    $display("FAIL param_overlap k=%0d got drive=1 oe_n=0 want exclusive", k);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_random_txn();
        test_back_to_back();
        test_reset_mid();
        test_err_saturate();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
